l2_cache_control: RTL and testbench
===================================

# l2_cache_control

Sequencing FSM for the 4-way L2 cache. Drives the state strobes that the L2 hit/select logic consumes: `idling`, `tag_comp`, and allocation. Runs the miss path toward physical memory: dirty-victim writeback, then line fill. Sits between the L1-facing request port and the pmem interface, alongside the L2 datapath and hit/select logic.

## Interface
Parameters:
- `CNT_W`, 32: width of the optional performance counters.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_read`  in  1  L1-side read request; held until serviced.
- `mem_write`  in  1  L1-side write request; held until serviced.
- `any_hit`  in  1  OR of per-way (valid & tag compare), taken from the datapath.
- `victim_dirty`  in  1  dirty bit of the LRU way at the current set index.
- `pmem_resp`  in  1  physical memory done; one-cycle pulse.
- `idling`  out  1  FSM in S_IDLE.
- `tag_comp`  out  1  FSM in S_TAG_COMP.
- `alloc`  out  1  fill in progress; gates the per-way alloc/dirty-clear write enables.
- `pmem_read`  out  1  line fill request.
- `pmem_write`  out  1  victim writeback request.
- `pmem_addr_sel`  out  1  pmem address select: 1 = victim tag/set, 0 = request address.
- `hit_count`, `miss_count`, `wb_count`  out  CNT_W  each; present only with `L2_PERF_COUNTERS_EN`.

## Operation
States: S_IDLE, S_TAG_COMP, S_WRITEBACK, S_ALLOCATE. Outputs are Moore-decoded from the registered state.
- **S_IDLE**
  - Outputs: `idling=1`.
  - req = `mem_read | mem_write`.
  - req & `any_hit`: stay. The hit/select logic returns `mem_resp` combinationally.
  - req & !`any_hit` & `victim_dirty`: go to S_WRITEBACK.
  - req & !`any_hit` & !`victim_dirty`: go to S_ALLOCATE.
  - No req: stay.
- **S_WRITEBACK**
  - Outputs: `pmem_write=1`, `pmem_addr_sel=1`.
  - Held until `pmem_resp`, then go to S_ALLOCATE.
- **S_ALLOCATE**
  - Outputs: `pmem_read=1`, `alloc=1`, `pmem_addr_sel=0`.
  - Held until `pmem_resp`, then go to S_TAG_COMP. The fill writes on the `pmem_resp` cycle.
- **S_TAG_COMP**
  - Outputs: `tag_comp=1`.
  - `any_hit`: go to S_IDLE. `mem_resp`, LRU update and dirty update happen this cycle in the hit/select logic.
  - !`any_hit` (line displaced or request changed): re-enter the miss path using the same `victim_dirty` rule as S_IDLE.
- **Boundary rules**
  - `mem_read` & `mem_write` together are illegal upstream. They are treated as a single request and the FSM is unchanged.
  - Request dropped mid-miss: the writeback/fill still completes. S_TAG_COMP then goes to S_IDLE; no `mem_resp` is produced because hit/select gates it on request.
  - `pmem_resp` in S_IDLE or S_TAG_COMP: ignored.
  - At most one of `idling`, `tag_comp`, `pmem_read`, `pmem_write` is high at any time.

## Timing
- Reset: on a clock edge with `rst=1`, state becomes S_IDLE.
  - Outputs then: `idling=1`; `tag_comp`, `alloc`, `pmem_read`, `pmem_write`, `pmem_addr_sel` = 0; counters = 0.
  - Reset mid-miss drops `pmem_read`/`pmem_write` at that edge. A later `pmem_resp` for the abandoned access is ignored.
- Hit latency: 0 cycles. `mem_resp` is in the same cycle as the request in S_IDLE.
- Clean miss: req → S_ALLOCATE (1 edge) → N cycles until `pmem_resp` → S_TAG_COMP (1 cycle) → S_IDLE.
- Dirty miss: adds S_WRITEBACK ahead of the fill. `pmem_write` drops on the edge after `pmem_resp`, and `pmem_read` rises on that same edge.
- `pmem_read`/`pmem_write` are held stable and continuously until `pmem_resp`; they never toggle mid-access.

## Configuration
- `L2_PERF_COUNTERS_EN` defined: the three `CNT_W`-bit counters and their ports are built.
  - `hit_count`: increments on S_IDLE & req & `any_hit`.
  - `miss_count`: increments on S_IDLE & req & !`any_hit`.
  - `wb_count`: increments on S_WRITEBACK & `pmem_resp`.
  - All counters wrap modulo 2^CNT_W and are cleared by `rst`.
- Undefined: no counter logic and no counter ports. FSM behaviour is identical in both builds.

## Test plan
- **Reset:** `rst` high 2 cycles, with `pmem_resp` pulsed during reset → `idling=1`, all other outputs 0, counters 0.
- **Hit:** `mem_read=1`, `any_hit=1` for 3 cycles → state stays S_IDLE, no pmem activity, `hit_count=3`.
- **Clean miss:** `mem_read=1`, `any_hit=0`, `victim_dirty=0`; `pmem_resp` after 5 cycles; `any_hit=1` in S_TAG_COMP → sequence S_ALLOCATE(6 cycles) → S_TAG_COMP → S_IDLE, `alloc=1` throughout the fill, `miss_count=1`.
- **Dirty miss:** `mem_write=1`, `victim_dirty=1`; `pmem_resp` after 3 cycles per access → `pmem_write` 4 cycles with `pmem_addr_sel=1`, then `pmem_read` 4 cycles with `pmem_addr_sel=0`, `wb_count=1`.
- **Reset mid-fill:** `rst` asserted in cycle 2 of S_ALLOCATE, `pmem_resp` one cycle later → `pmem_read=0` after the reset edge, state S_IDLE, the late response is ignored.
- **Request dropped during writeback:** `mem_read` cleared during S_WRITEBACK → the full writeback and fill still complete, then S_TAG_COMP → S_IDLE with no hang.

Source files
------------

// File: rtl/l2_cache_control.sv
// l2_cache_control: sequencing FSM for the 4-way L2 cache.
// Moore-decodes the idle, tag-compare and allocate strobes for the hit/select
// logic, and runs the miss path toward pmem: dirty-victim writeback, then fill.
// Ports:
//   clk, rst (synchronous, active-high)
//   mem_read, mem_write : L1-side request, held until serviced
//   any_hit             : OR of per-way valid & tag match
//   victim_dirty        : dirty bit of the LRU way at the current set
//   pmem_resp           : one-cycle done pulse from physical memory
//   idling, tag_comp, alloc : state strobes for the hit/select logic
//   pmem_read, pmem_write   : fill / writeback requests
//   pmem_addr_sel           : 1 = victim tag/set, 0 = request address
//   hit_count, miss_count, wb_count : CNT_W-bit performance counters, built
//                                     only when L2_PERF_COUNTERS_EN is defined
module l2_cache_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             any_hit,
    input  logic             victim_dirty,
    input  logic             pmem_resp,
    output logic             idling,
    output logic             tag_comp,
    output logic             alloc,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_addr_sel
`ifdef L2_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
`endif
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_TAG_COMP  = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_ALLOCATE  = 2'd3;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       req;
    logic [1:0] miss_next;

    // Read and write together is illegal upstream; OR-ing them folds it
    // into a single request.
    assign req       = mem_read | mem_write;
    assign miss_next = victim_dirty ? S_WRITEBACK : S_ALLOCATE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req && !any_hit) begin
                    state_d = miss_next;
                end
            end
            S_WRITEBACK: begin
                if (pmem_resp) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                if (pmem_resp) begin
                    state_d = S_TAG_COMP;
                end
            end
            S_TAG_COMP: begin
                // A dropped request returns to idle even without a hit;
                // a still-pending request that misses re-enters the miss path.
                if (any_hit || !req) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = miss_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign idling        = (state_q == S_IDLE);
    assign tag_comp      = (state_q == S_TAG_COMP);
    assign pmem_write    = (state_q == S_WRITEBACK);
    assign pmem_read     = (state_q == S_ALLOCATE);
    assign alloc         = (state_q == S_ALLOCATE);
    assign pmem_addr_sel = (state_q == S_WRITEBACK);

`ifdef L2_PERF_COUNTERS_EN
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0] wb_q, wb_d;

    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        wb_d   = wb_q;
        if (idling && req && any_hit) begin
            hit_d = hit_q + ONE;
        end
        if (idling && req && !any_hit) begin
            miss_d = miss_q + ONE;
        end
        if (pmem_write && pmem_resp) begin
            wb_d = wb_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
            wb_q   <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
            wb_q   <= wb_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;
`endif

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed bench for l2_cache_control: a phase-level model of the miss
// sequence is checked every cycle, plus hand-computed cycle counts.
module tb_l2_cache_control;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_read = 1'b0;
    logic mem_write = 1'b0;
    logic any_hit = 1'b0;
    logic victim_dirty = 1'b0;
    logic pmem_resp = 1'b0;
    logic idling, tag_comp, alloc, pmem_read, pmem_write, pmem_addr_sel;
`ifdef L2_PERF_COUNTERS_EN
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;
`endif

    l2_cache_control #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .any_hit(any_hit),
        .victim_dirty(victim_dirty),
        .pmem_resp(pmem_resp),
        .idling(idling),
        .tag_comp(tag_comp),
        .alloc(alloc),
        .pmem_read(pmem_read),
        .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel)
`ifdef L2_PERF_COUNTERS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count),
        .wb_count(wb_count)
`endif
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    function automatic void chk(string name, longint act, longint exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: which activity the controller is engaged in.
    typedef enum int { P_IDLE, P_CHECK, P_WRITEBACK, P_FILL } phase_t;
    phase_t ph = P_IDLE;
    bit     armed = 1'b0;
    longint m_hits = 0, m_misses = 0, m_wbs = 0;

    always @(posedge clk) begin
        automatic bit want = mem_read || mem_write;
        automatic phase_t miss_ph = victim_dirty ? P_WRITEBACK : P_FILL;
        if (rst) begin
            ph <= P_IDLE;
            m_hits <= 0;
            m_misses <= 0;
            m_wbs <= 0;
            armed <= 1'b1;
        end else begin
            if (ph == P_IDLE && want && any_hit) m_hits <= m_hits + 1;
            if (ph == P_IDLE && want && !any_hit) m_misses <= m_misses + 1;
            if (ph == P_WRITEBACK && pmem_resp) m_wbs <= m_wbs + 1;
            if (ph == P_IDLE) begin
                if (want && !any_hit) ph <= miss_ph;
            end else if (ph == P_WRITEBACK) begin
                if (pmem_resp) ph <= P_FILL;
            end else if (ph == P_FILL) begin
                if (pmem_resp) ph <= P_CHECK;
            end else begin
                ph <= (any_hit || !want) ? P_IDLE : miss_ph;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("idling", idling, ph == P_IDLE);
            chk("tag_comp", tag_comp, ph == P_CHECK);
            chk("pmem_write", pmem_write, ph == P_WRITEBACK);
            chk("pmem_read", pmem_read, ph == P_FILL);
            chk("alloc", alloc, ph == P_FILL);
            chk("addr_sel", pmem_addr_sel, ph == P_WRITEBACK);
            chk("onehot", $countones({idling, tag_comp, pmem_read, pmem_write}) <= 1, 1);
`ifdef L2_PERF_COUNTERS_EN
            chk("hit_count", hit_count, m_hits);
            chk("miss_count", miss_count, m_misses);
            chk("wb_count", wb_count, m_wbs);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int n_a, n_b;

    initial begin
        // Reset for two cycles with a stray pmem_resp
        rst = 1'b1;
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_idling", idling, 1);
        chk("rst_quiet", {tag_comp, alloc, pmem_read, pmem_write, pmem_addr_sel}, 0);
`ifdef L2_PERF_COUNTERS_EN
        chk("rst_cnt", hit_count + miss_count + wb_count, 0);
`endif

        // Hit for three cycles
        mem_read = 1'b1;
        any_hit = 1'b1;
        repeat (3) tick();
        chk("hit_idle", idling, 1);
        mem_read = 1'b0;
`ifdef L2_PERF_COUNTERS_EN
        chk("hit_count_lit", hit_count, 3);
`endif

        // Illegal read+write with hit, plus stray pmem_resp in idle
        mem_read = 1'b1;
        mem_write = 1'b1;
        pmem_resp = 1'b1;
        tick();
        mem_read = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        chk("rw_idle", idling, 1);

        // Clean miss: resp in the 6th allocate cycle
        mem_read = 1'b1;
        any_hit = 1'b0;
        victim_dirty = 1'b0;
        tick();
        n_a = 0;
        for (int i = 0; i < 6; i++) begin
            if (pmem_read && alloc && !pmem_addr_sel) n_a++;
            pmem_resp = (i == 5);
            tick();
        end
        pmem_resp = 1'b0;
        chk("clean_alloc_cycles", n_a, 6);
        chk("clean_tag_comp", tag_comp, 1);
        any_hit = 1'b1;
        tick();
        chk("clean_back_idle", idling, 1);
        mem_read = 1'b0;
`ifdef L2_PERF_COUNTERS_EN
        chk("miss_count_lit", miss_count, 1);
`endif

        // Dirty miss: 4 writeback cycles then 4 fill cycles
        mem_write = 1'b1;
        any_hit = 1'b0;
        victim_dirty = 1'b1;
        tick();
        n_a = 0;
        n_b = 0;
        for (int i = 0; i < 4; i++) begin
            if (pmem_write && pmem_addr_sel) n_a++;
            pmem_resp = (i == 3);
            tick();
        end
        pmem_resp = 1'b0;
        chk("dirty_handoff", {pmem_write, pmem_read}, 1);
        for (int i = 0; i < 4; i++) begin
            if (pmem_read && !pmem_addr_sel) n_b++;
            pmem_resp = (i == 3);
            tick();
        end
        pmem_resp = 1'b0;
        chk("dirty_wb_cycles", n_a, 4);
        chk("dirty_fill_cycles", n_b, 4);
        any_hit = 1'b1;
        tick();
        chk("dirty_back_idle", idling, 1);
        mem_write = 1'b0;
        victim_dirty = 1'b0;
`ifdef L2_PERF_COUNTERS_EN
        chk("wb_count_lit", wb_count, 1);
`endif

        // Reset in the second allocate cycle, late resp ignored
        mem_read = 1'b1;
        any_hit = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        mem_read = 1'b0;
        tick();
        rst = 1'b0;
        chk("rstfill_read_drop", pmem_read, 0);
        chk("rstfill_idle", idling, 1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("late_resp_ignored", idling, 1);
        tick();

        // Request dropped during writeback
        mem_read = 1'b1;
        victim_dirty = 1'b1;
        tick();
        chk("drop_in_wb", pmem_write, 1);
        tick();
        mem_read = 1'b0;
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("drop_fill", pmem_read, 1);
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("drop_tag_comp", tag_comp, 1);
        tick();
        chk("drop_idle", idling, 1);
        victim_dirty = 1'b0;

        // Tag compare misses again while the request is held: re-miss dirty
        mem_read = 1'b1;
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("remiss_tag_comp", tag_comp, 1);
        victim_dirty = 1'b1;
        tick();
        chk("remiss_wb", pmem_write, 1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        any_hit = 1'b1;
        tick();
        chk("remiss_idle", idling, 1);
        mem_read = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
